rq_gearbox: RTL

Parametrised requester-request (RQ) gearbox that merges a 128-bit (4-DW) request descriptor with a user payload stream and emits a width-aligned AXI-Stream toward the PCIe core's `s_axis_rq` port. Each packet's payload is shifted up by 4 DW across beat boundaries, and a trailing flush beat is inserted when the remnant does not fit. The block supports 256- and 512-bit datapaths and honours full AXI backpressure (output held stable while not ready). It checks the user's beat count against the declared length. It sits between the DMA write/read request generators and the PCIe hard IP.

---
 rtl/rq_gearbox.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/rq_gearbox.sv
// rtl/rq_gearbox.sv - merges a 4-DW RQ descriptor with payload beats into an aligned s_axis_rq stream
// Payload is shifted up by 4 DW; a flush beat carries any remnant that overflows the last beat.
module rq_gearbox #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 60
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [127:0]             descriptor,
  input  logic [3:0]               rq_first_be,
  input  logic [3:0]               rq_last_be,
  input  logic [10:0]              rq_dword_count,
  input  logic [DATA_WIDTH-1:0]    rq_wr_data,
  input  logic                     rq_valid,
  input  logic                     rq_sop,
  input  logic                     rq_last,
  output logic                     rq_ready,
  output logic [DATA_WIDTH-1:0]    s_axis_rq_tdata,
  output logic                     s_axis_rq_tvalid,
  output logic [TUSER_WIDTH-1:0]   s_axis_rq_tuser,
  output logic [DATA_WIDTH/32-1:0] s_axis_rq_tkeep,
  output logic                     s_axis_rq_tlast,
  input  logic                     s_axis_rq_tready,
  output logic                     err_len
);

  localparam int W  = DATA_WIDTH / 32;
  localparam int LW = $clog2(W);
  localparam int CW = LW + 1;

  typedef enum logic [1:0] {IDLE, BODY, FLUSH} state_t;

  state_t                 r_state, w_next;
  logic [127:0]           r_carry;
  logic [10:0]            r_exp_beats, r_beat_cnt;
  logic                   r_need_flush;
  logic [CW-1:0]          r_tail_n;
  logic [DATA_WIDTH-1:0]  r_tdata, w_tdata;
  logic                   r_tvalid, w_tvalid;
  logic [TUSER_WIDTH-1:0] r_tuser, w_tuser;
  logic [W-1:0]           r_tkeep, w_tkeep;
  logic                   r_tlast, w_tlast;
  logic                   r_err_len, w_err;

  logic          w_adv, w_ready, w_acc;
  logic [LW-1:0] w_sop_rem, w_sop_tsum;
  logic [CW-1:0] w_sop_r, w_sop_tail, w_tail_eff;
  logic [10:0]   w_sop_exp, w_exp_eff, w_cnt_eff;
  logic          w_sop_flush, w_flush_eff;

  function automatic logic [W-1:0] keep_mask(input logic [CW-1:0] n);
    return ~({W{1'b1}} << n);
  endfunction

  assign w_adv   = !r_tvalid || s_axis_rq_tready;
  assign w_ready = w_adv && (r_state != FLUSH) && !rst;
  assign w_acc   = rq_valid && w_ready;

  // Per-packet geometry from the SOP sideband; a residue of 0 means a full last beat.
  assign w_sop_rem   = rq_dword_count[LW-1:0];
  assign w_sop_tsum  = rq_dword_count[LW-1:0] + LW'(4);
  assign w_sop_r     = (w_sop_rem == '0) ? CW'(W) : {1'b0, w_sop_rem};
  assign w_sop_tail  = (w_sop_tsum == '0) ? CW'(W) : {1'b0, w_sop_tsum};
  assign w_sop_flush = w_sop_r > CW'(W - 4);
  assign w_sop_exp   = 11'((rq_dword_count + 11'(W - 1)) >> LW);

  assign w_flush_eff = rq_sop ? w_sop_flush : r_need_flush;
  assign w_tail_eff  = rq_sop ? w_sop_tail  : r_tail_n;
  assign w_exp_eff   = rq_sop ? w_sop_exp   : r_exp_beats;
  assign w_cnt_eff   = rq_sop ? 11'd1       : r_beat_cnt + 11'd1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FLUSH: if (w_adv) w_next = IDLE;
      default: begin
        if (w_acc && (rq_sop || r_state == BODY)) begin
          if (rq_last) w_next = w_flush_eff ? FLUSH : IDLE;
          else         w_next = BODY;
        end
      end
    endcase
  end

  always_comb begin
    w_tdata  = r_tdata;
    w_tvalid = r_tvalid;
    w_tuser  = r_tuser;
    w_tkeep  = r_tkeep;
    w_tlast  = r_tlast;
    w_err    = 1'b0;
    if (w_adv) begin
      w_tdata  = '0;
      w_tvalid = 1'b0;
      w_tuser  = '0;
      w_tkeep  = '0;
      w_tlast  = 1'b0;
      if (r_state == FLUSH) begin
        w_tdata  = DATA_WIDTH'(r_carry);
        w_tvalid = 1'b1;
        w_tkeep  = keep_mask(r_tail_n);
        w_tlast  = 1'b1;
      end else if (w_acc) begin
        if (rq_sop || r_state == BODY) begin
          w_tvalid = 1'b1;
          w_tdata  = {rq_wr_data[DATA_WIDTH-129:0], (rq_sop ? descriptor : r_carry)};
          w_tkeep  = {W{1'b1}};
          if (rq_sop) begin
            w_tuser = TUSER_WIDTH'({rq_last_be, rq_first_be});
            w_err   = (r_state != IDLE);
          end
          if (rq_last) begin
            w_err   = w_err || (w_cnt_eff != w_exp_eff);
            w_tlast = !w_flush_eff;
            w_tkeep = w_flush_eff ? {W{1'b1}} : keep_mask(w_tail_eff);
          end
        end else begin
          w_err = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry      <= '0;
      r_exp_beats  <= '0;
      r_beat_cnt   <= '0;
      r_need_flush <= 1'b0;
      r_tail_n     <= '0;
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_tuser      <= '0;
      r_tkeep      <= '0;
      r_tlast      <= 1'b0;
      r_err_len    <= 1'b0;
    end else begin
      if (w_acc) r_carry <= rq_wr_data[DATA_WIDTH-1 -: 128];
      if (w_acc && rq_sop) begin
        r_exp_beats  <= w_sop_exp;
        r_need_flush <= w_sop_flush;
        r_tail_n     <= w_sop_tail;
        r_beat_cnt   <= 11'd1;
      end else if (w_acc && r_state == BODY) begin
        r_beat_cnt <= r_beat_cnt + 11'd1;
      end
      r_tdata   <= w_tdata;
      r_tvalid  <= w_tvalid;
      r_tuser   <= w_tuser;
      r_tkeep   <= w_tkeep;
      r_tlast   <= w_tlast;
      r_err_len <= w_err;
    end
  end

  assign rq_ready         = w_ready;
  assign s_axis_rq_tdata  = r_tdata;
  assign s_axis_rq_tvalid = r_tvalid;
  assign s_axis_rq_tuser  = r_tuser;
  assign s_axis_rq_tkeep  = r_tkeep;
  assign s_axis_rq_tlast  = r_tlast;
  assign err_len          = r_err_len;

endmodule
